// File: rtl/mem_port_arbiter_if.sv
// Bundle of every signal between the arbiter, the two pipeline requesters
// (fetch and memory stage) and the shared single-ported memory.
// The arbiter uses the slave view; the requesters and memory model use master.
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             if_req;
    logic [WIDTH-1:0] if_addr;
    logic             if_gnt;
    logic             if_valid;
    logic [WIDTH-1:0] if_rdata;

    logic             d_req;
    logic             d_we;
    logic [2:0]       d_size;
    logic [WIDTH-1:0] d_addr;
    logic [WIDTH-1:0] d_wdata;
    logic             d_gnt;
    logic             d_valid;
    logic [WIDTH-1:0] d_rdata;

    logic             bus_err;

    logic             mem_req;
    logic             mem_we;
    logic [2:0]       mem_size;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        input  mem_ack, mem_rdata,
        output if_gnt, if_valid, if_rdata,
        output d_gnt, d_valid, d_rdata,
        output bus_err,
        output mem_req, mem_we, mem_size, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_size, d_addr, d_wdata,
        output mem_ack, mem_rdata,
        input  if_gnt, if_valid, if_rdata,
        input  d_gnt, d_valid, d_rdata,
        input  bus_err,
        input  mem_req, mem_we, mem_size, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch stage
// and the memory stage. One transaction is outstanding at a time. Data wins
// ties, a saturating starvation counter eventually forces a fetch grant, and
// a per-transaction timeout completes a hung access with bus_err.
// All outputs are flops; nothing on the bus is combinational from an input.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [WW-1:0]    WAIT_LAST  = WW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit               TO_EN      = (TIMEOUT != 0);
    localparam logic [WIDTH-1:0] ZERO       = '0;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic          owner_fetch;
    logic [SW-1:0] starve_cnt;
    logic [WW-1:0] wait_cnt;
    logic          pick_fetch;

    // Fetch wins when it is alone, or when it has lost STARVE_MAX ties in a row.
    assign pick_fetch = bus.if_req && (!bus.d_req || (starve_cnt == STARVE_LIM));

    // Transaction FSM; the mem_* registers double as the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner_fetch   <= 1'b0;
            starve_cnt    <= '0;
            wait_cnt      <= '0;
            bus.if_gnt    <= 1'b0;
            bus.if_valid  <= 1'b0;
            bus.if_rdata  <= '0;
            bus.d_gnt     <= 1'b0;
            bus.d_valid   <= 1'b0;
            bus.d_rdata   <= '0;
            bus.bus_err   <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_size  <= 3'b000;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.if_gnt   <= 1'b0;
            bus.d_gnt    <= 1'b0;
            bus.mem_req  <= 1'b0;
            bus.if_valid <= 1'b0;
            bus.d_valid  <= 1'b0;
            bus.if_rdata <= '0;
            bus.d_rdata  <= '0;
            bus.bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.d_req) begin
                        owner_fetch <= pick_fetch;
                        bus.mem_req <= 1'b1;
                        state       <= ISSUE;
                        if (pick_fetch) begin
                            bus.if_gnt    <= 1'b1;
                            bus.mem_we    <= 1'b0;
                            bus.mem_size  <= 3'b100;
                            bus.mem_addr  <= bus.if_addr;
                            bus.mem_wdata <= ZERO;
                            starve_cnt    <= '0;
                        end else begin
                            bus.d_gnt     <= 1'b1;
                            bus.mem_we    <= bus.d_we;
                            bus.mem_size  <= bus.d_size;
                            bus.mem_addr  <= bus.d_addr;
                            bus.mem_wdata <= bus.d_wdata;
                            if (bus.if_req && (starve_cnt != STARVE_LIM)) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (bus.mem_ack) begin
                        state <= RESP;
                        if (owner_fetch) begin
                            bus.if_valid <= 1'b1;
                            bus.if_rdata <= bus.mem_rdata;
                        end else begin
                            bus.d_valid <= 1'b1;
                            bus.d_rdata <= bus.mem_we ? ZERO : bus.mem_rdata;
                        end
                    end else if (TO_EN && (wait_cnt == WAIT_LAST)) begin
                        state        <= RESP;
                        bus.bus_err  <= 1'b1;
                        bus.if_valid <= owner_fetch;
                        bus.d_valid  <= !owner_fetch;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Directed scenario tasks drive the
// requesters and act as the memory; every ack pushes the expected response
// onto a queue that a negedge monitor pops and compares on each valid pulse.
module tb_mem_port_arbiter;
    localparam int WIDTH = 32;

    typedef struct packed {
        logic             fetch;
        logic [WIDTH-1:0] rdata;
        logic             err;
    } resp_t;

    logic  clk = 1'b0;
    logic  rst;
    resp_t exp_q[$];
    resp_t mon_e;
    logic [WIDTH-1:0] mon_own_rdata;
    logic [WIDTH-1:0] mon_other_rdata;
    int    tests_run    = 0;
    int    tests_failed = 0;

    mem_port_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mem_port_arbiter #(.WIDTH(WIDTH), .STARVE_MAX(2), .TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Scoreboard monitor: each valid pulse must match the oldest expected response
    always @(negedge clk) begin
        if (!rst && (bus.if_valid || bus.d_valid)) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_valid: if_valid=%b d_valid=%b, required no response", bus.if_valid, bus.d_valid);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.if_valid, bus.d_valid} !== (mon_e.fetch ? 2'b10 : 2'b01)) begin
                    tests_failed++;
                    $display("[TB] FAIL resp_port: got if/d valid=%b%b, want fetch=%b", bus.if_valid, bus.d_valid, mon_e.fetch);
                end
                mon_own_rdata   = mon_e.fetch ? bus.if_rdata : bus.d_rdata;
                mon_other_rdata = mon_e.fetch ? bus.d_rdata  : bus.if_rdata;
                tests_run++;
                if (mon_own_rdata !== mon_e.rdata) begin
                    tests_failed++;
                    $display("[TB] FAIL resp_rdata: got %h, want %h", mon_own_rdata, mon_e.rdata);
                end
                tests_run++;
                if (bus.bus_err !== mon_e.err) begin
                    tests_failed++;
                    $display("[TB] FAIL resp_err: got %b, want %b", bus.bus_err, mon_e.err);
                end
                tests_run++;
                if (mon_other_rdata !== '0) begin
                    tests_failed++;
                    $display("[TB] FAIL nonowner_rdata: got %h, want 0", mon_other_rdata);
                end
            end
        end
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic fetch, input logic [WIDTH-1:0] rdata, input logic err);
        resp_t item;
        item.fetch = fetch;
        item.rdata = rdata;
        item.err   = err;
        exp_q.push_back(item);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0040;
        bus.d_req = 1'b1;  bus.d_addr = 32'h0000_0080; bus.d_size = 3'b100;
        tick();
        tests_run++; if (bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_gnt: got if=%b d=%b, want 0 0", bus.if_gnt, bus.d_gnt); end
        tests_run++; if (bus.mem_req !== 1'b0 || bus.mem_addr !== '0 || bus.mem_size !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_mem: got req=%b addr=%h size=%b, want 0", bus.mem_req, bus.mem_addr, bus.mem_size); end
        tests_run++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0 || bus.bus_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got if=%b d=%b err=%b, want 0", bus.if_valid, bus.d_valid, bus.bus_err); end
        tick();
        tests_run++; if (bus.if_gnt !== 1'b0 || bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_wins: got gnt=%b req=%b, want 0 0", bus.if_gnt, bus.mem_req); end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_fetch();
        bus.if_req = 1'b1; bus.if_addr = 32'hBFC0_0000;
        tick();
        tests_run++; if (bus.if_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL fetch_gnt: got %b, want 1", bus.if_gnt); end
        tests_run++; if (bus.mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL fetch_mem_req: got %b, want 1", bus.mem_req); end
        tests_run++; if (bus.mem_addr !== 32'hBFC0_0000) begin tests_failed++; $display("[TB] FAIL fetch_addr: got %h, want bfc00000", bus.mem_addr); end
        tests_run++; if (bus.mem_size !== 3'b100 || bus.mem_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL fetch_size: got size=%b we=%b, want 100 0", bus.mem_size, bus.mem_we); end
        tests_run++; if (bus.d_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL fetch_dgnt: got %b, want 0", bus.d_gnt); end
        bus.if_req = 1'b0;
        tick();
        tests_run++; if (bus.mem_req !== 1'b0 || bus.if_gnt !== 1'b0) begin tests_failed++; $display("[TB] FAIL fetch_strobe: got req=%b gnt=%b, want 0 0", bus.mem_req, bus.if_gnt); end
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0050_0093;
        push_exp(1'b1, 32'h0050_0093, 1'b0);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tests_run++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h0050_0093) begin tests_failed++; $display("[TB] FAIL fetch_resp: got valid=%b rdata=%h, want 1 00500093", bus.if_valid, bus.if_rdata); end
        tick();
        tests_run++; if (bus.if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL fetch_valid_pulse: got %b, want 0", bus.if_valid); end
    endtask

    task automatic test_store();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 3'b001;
        bus.d_addr = 32'h0001_0003; bus.d_wdata = 32'h0000_00AB;
        tick();
        tests_run++; if (bus.d_gnt !== 1'b1 || bus.mem_req !== 1'b1) begin tests_failed++; $display("[TB] FAIL store_gnt: got gnt=%b req=%b, want 1 1", bus.d_gnt, bus.mem_req); end
        tests_run++; if (bus.mem_we !== 1'b1 || bus.mem_size !== 3'b001) begin tests_failed++; $display("[TB] FAIL store_ctrl: got we=%b size=%b, want 1 001", bus.mem_we, bus.mem_size); end
        tests_run++; if (bus.mem_wdata !== 32'h0000_00AB || bus.mem_addr !== 32'h0001_0003) begin tests_failed++; $display("[TB] FAIL store_data: got wdata=%h addr=%h, want ab 10003", bus.mem_wdata, bus.mem_addr); end
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
        push_exp(1'b0, '0, 1'b0);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tests_run++; if (bus.d_valid !== 1'b1 || bus.d_rdata !== '0) begin tests_failed++; $display("[TB] FAIL store_resp: got valid=%b rdata=%h, want 1 0", bus.d_valid, bus.d_rdata); end
        tick();
    endtask

    task automatic test_priority_starvation();
        bit [5:0] got_order;
        bit [5:0] want_order;
        int       n;
        bit       ack_pending;
        bit       last_fetch;
        got_order   = '0;
        want_order  = 6'b100100;
        n           = 0;
        ack_pending = 1'b0;
        last_fetch  = 1'b0;
        bus.if_addr = 32'h0000_1000;
        bus.d_we = 1'b0; bus.d_size = 3'b100; bus.d_addr = 32'h0000_8000; bus.d_wdata = '0;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        for (int cyc = 0; cyc < 80 && n < 6; cyc++) begin
            tick();
            bus.mem_ack = 1'b0;
            if (ack_pending) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hC0DE_0000 + 32'(n);
                push_exp(last_fetch, 32'hC0DE_0000 + 32'(n), 1'b0);
                ack_pending = 1'b0;
            end
            if (bus.if_valid) bus.if_req = 1'b1;
            if (bus.d_valid)  bus.d_req  = 1'b1;
            if (bus.mem_req) begin
                last_fetch   = bus.if_gnt;
                got_order[n] = bus.if_gnt;
                n++;
                if (bus.if_gnt) bus.if_req = 1'b0;
                else            bus.d_req  = 1'b0;
                ack_pending = 1'b1;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        tests_run++; if (n != 6) begin tests_failed++; $display("[TB] FAIL starve_grants: got %0d grants, want 6", n); end
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if (got_order[i] !== want_order[i]) begin
                tests_failed++;
                $display("[TB] FAIL starve_order[%0d]: got %s, want %s", i, got_order[i] ? "F" : "D", want_order[i] ? "F" : "D");
            end
        end
        tick();
        bus.mem_ack = 1'b0;
        if (ack_pending) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hC0DE_0000 + 32'(n);
            push_exp(last_fetch, 32'hC0DE_0000 + 32'(n), 1'b0);
        end
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0400;
        push_exp(1'b1, '0, 1'b1);
        tick();
        tests_run++; if (bus.if_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_gnt: got %b, want 1", bus.if_gnt); end
        bus.if_req = 1'b0;
        repeat (4) tick();
        tests_run++; if (bus.if_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_early: got valid=%b at cycle 5, want 0", bus.if_valid); end
        tick();
        tests_run++; if (bus.if_valid !== 1'b1 || bus.bus_err !== 1'b1 || bus.if_rdata !== '0) begin tests_failed++; $display("[TB] FAIL timeout_resp: got valid=%b err=%b rdata=%h, want 1 1 0", bus.if_valid, bus.bus_err, bus.if_rdata); end
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_1234;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tests_run++; if (bus.if_valid !== 1'b0 || bus.d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL late_ack: got if=%b d=%b, want 0 0", bus.if_valid, bus.d_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_2000;
        tick();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_2000) begin tests_failed++; $display("[TB] FAIL b2b_req1: got req=%b addr=%h, want 1 2000", bus.mem_req, bus.mem_addr); end
        bus.if_req = 1'b0;
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_0001;
        push_exp(1'b1, 32'h1111_0001, 1'b0);
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_2004;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tests_run++; if (bus.if_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid1: got %b at cycle 3, want 1", bus.if_valid); end
        tick();
        tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_gap: got req=%b at cycle 4, want 0", bus.mem_req); end
        tick();
        tests_run++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0000_2004) begin tests_failed++; $display("[TB] FAIL b2b_req2: got req=%b addr=%h, want 1 2004", bus.mem_req, bus.mem_addr); end
        bus.if_req = 1'b0;
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h2222_0002;
        push_exp(1'b1, 32'h2222_0002, 1'b0);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tests_run++; if (bus.if_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_valid2: got %b at cycle 7, want 1", bus.if_valid); end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 3'b100; bus.d_addr = 32'h0000_5000;
        tick();
        tests_run++; if (bus.d_gnt !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstwait_gnt: got %b, want 1", bus.d_gnt); end
        bus.d_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++; if (bus.mem_addr !== '0 || bus.mem_size !== 3'b000 || bus.mem_we !== 1'b0 || bus.mem_req !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstwait_mem: got addr=%h size=%b we=%b req=%b, want 0", bus.mem_addr, bus.mem_size, bus.mem_we, bus.mem_req); end
        tests_run++; if (bus.d_valid !== 1'b0 || bus.d_gnt !== 1'b0 || bus.d_rdata !== '0 || bus.bus_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstwait_port: got valid=%b gnt=%b rdata=%h err=%b, want 0", bus.d_valid, bus.d_gnt, bus.d_rdata, bus.bus_err); end
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0BAD;
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tests_run++; if (bus.d_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstwait_ack: got d_valid=%b, want 0", bus.d_valid); end
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_3000;
        tick();
        tests_run++; if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h0000_3000) begin tests_failed++; $display("[TB] FAIL rstwait_refetch: got gnt=%b addr=%h, want 1 3000", bus.if_gnt, bus.mem_addr); end
        bus.if_req = 1'b0;
        tick();
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0077;
        push_exp(1'b1, 32'h0000_0077, 1'b0);
        tick();
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        tick();
        tick();
    endtask

    // Scenario sequence and final summary
    initial begin
        rst = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 3'b000; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        test_reset();
        test_single_fetch();
        test_store();
        test_priority_starvation();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL missing_resp: got %0d responses outstanding, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single-ported unified instruction/data memory between two requesters: the fetch stage (read-only instruction port) and the memory stage (load/store data port). Only one memory transaction is outstanding at a time. The block is a registered-output FSM with data-port priority, a starvation counter that guarantees fetch progress, and a per-transaction timeout. It replaces the separate instruction and data memories behind the fetch and memory stages; the pipeline stalls a stage while that stage's request is pending.

## Interface
- WIDTH, 32, address/data width
- STARVE_MAX, 4, consecutive fetch-pending arbitration losses before fetch is forced to win (≥1)
- TIMEOUT, 255, max cycles in WAIT before error completion; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  reset. Synchronous, active-high. One clock; reset is sampled on the rising edge of clk.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  WIDTH  fetch byte address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_valid  out  1  one-cycle pulse: fetch response
- if_rdata  out  WIDTH  instruction, valid with if_valid
- d_req  in  1  data request; held with d_* stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  3  one-hot size {word, half, byte}
- d_addr, d_wdata  in  WIDTH  data address, store data
- d_gnt, d_valid  out  1  as fetch port
- d_rdata  out  WIDTH  load data with d_valid; 0 for stores
- bus_err  out  1  pulses with the owner's valid on a timeout completion
- mem_req  out  1  one-cycle memory request strobe
- mem_we  out  1  write enable to memory
- mem_size  out  3  one-hot size to memory; fetch always drives 3'b100
- mem_addr, mem_wdata  out  WIDTH  memory address and write data
- mem_ack  in  1  memory completion; earliest one cycle after mem_req
- mem_rdata  in  WIDTH  read data, valid with mem_ack

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Every output is decoded from registered state and latched data only. There is no combinational input→output path.
- **IDLE**
  - If no request is pending: stay in IDLE.
  - Else pick the owner:
    - only one requester → that requester;
    - both requesting → data, unless starve_cnt == STARVE_MAX, then fetch.
  - Latch the owner and its addr/we/size/wdata; go to ISSUE.
- **ISSUE** (1 cycle)
  - mem_req = 1.
  - mem_* driven from the latched request.
  - Owner's gnt = 1.
  - Go to WAIT.
- **WAIT**
  - mem_* stay driven from the latched request; mem_req = 0.
  - On mem_ack: latch mem_rdata (latch 0 if the owner is data with we = 1); go to RESP.
  - Else if TIMEOUT ≠ 0 and wait_cnt == TIMEOUT−1: latch rdata = 0, set err; go to RESP.
  - Else wait_cnt++.
- **RESP** (1 cycle)
  - Owner's valid = 1 and owner's rdata = latched rdata.
  - bus_err = err.
  - Go to IDLE; clear err.
- starve_cnt (saturating, width clog2(STARVE_MAX+1)):
  - increments on an IDLE arbitration where both requesters are pending and data wins;
  - clears when fetch is granted.
- rdata outputs of the non-owner port hold 0.
- mem_ack outside WAIT is ignored. This includes a late ack after a timeout or after a reset.
- Requesters deassert req in the cycle after seeing gnt. A request held through RESP is re-arbitrated in the next IDLE.
- Reset: from any state, go to IDLE at the next edge.
  - starve_cnt, wait_cnt, err, latched owner/addr/data: 0.
  - All outputs: 0.
  - An in-flight transaction is abandoned; no valid is produced for it.

## Timing
- Request seen in IDLE at cycle N → gnt and mem_req at N+1 → WAIT from N+2.
- mem_ack sampled at cycle M (M ≥ N+2) → valid/rdata at M+1 → IDLE at M+2.
- Minimum turnaround: a request at N with ack at N+2 gives valid at N+3. The next mem_req is at N+5 at the earliest.
- Timeout: entering WAIT at cycle W with no ack gives valid plus bus_err at W+TIMEOUT.
- Simultaneous req and rst: reset wins; no gnt is issued.

## Test plan
- **Single fetch:** if_req = 1 with if_addr = 0xBFC00000 at cycle 0; mem_ack at cycle 3 with mem_rdata = 0x00500093.
  - if_gnt, mem_req, mem_addr = 0xBFC00000 and mem_size = 3'b100 at cycle 1.
  - if_valid with if_rdata = 0x00500093 at cycle 4; d_valid = 0 throughout.
- **Store:** d_req, d_we = 1, d_size = 3'b001, d_addr = 0x10003, d_wdata = 0xAB at cycle 0; ack at cycle 2.
  - mem_we = 1, mem_size = 3'b001, mem_wdata = 0xAB at cycle 1.
  - d_valid at cycle 3 with d_rdata = 0.
- **Priority and starvation:** STARVE_MAX = 2; both ports re-request immediately after each valid; memory acks one cycle after each mem_req.
  - Grant order is D, D, F, D, D, F.
- **Timeout:** TIMEOUT = 4, fetch request at cycle 0, no ack.
  - if_valid and bus_err = 1 at cycle 6 with if_rdata = 0.
  - A mem_ack at cycle 7 produces no valid.
- **Reset mid-WAIT:** rst at cycle 3 of an outstanding data load.
  - All outputs are 0 at cycle 4.
  - An ack at cycle 5 is ignored.
  - A new fetch request at cycle 6 gets if_gnt at cycle 7.
- **Minimum latency back-to-back:** ack always one cycle after mem_req, two fetches queued.
  - mem_req at cycles 1 and 5; if_valid at cycles 3 and 7.
